mds_seq: RTL and testbench

- Serial sequencer for the Twofish MDS 4x4 matrix multiply over GF(2^8).
- Time-shares one GF(2^8) multiplier and one 8-bit accumulator across all 16 matrix terms.
- Trades latency for area versus a fully parallel MDS.
- Sits between the q-permutation/S-box stage and the PHT in the g/h function path.
- Word-level valid/ready handshake on input and output.

---
 rtl/mds_pkg.sv | 48 ++++
 rtl/mds_seq_if.sv | 26 ++
 rtl/mds_gf_mul.sv | 26 ++
 rtl/mds_seq.sv | 166 ++++++++++++++++
 tb/tb_mds_seq.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mds_pkg.sv
// Shared definitions for the Twofish MDS serial sequencer.
// Contents: word/byte widths, reduction polynomial, MDS coefficient matrix,
// FSM state encoding and byte-lane access helpers.
package mds_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LANES  = 4;

    // x^8 + x^6 + x^5 + x^3 + 1
    localparam logic [8:0] MDS_POLY = 9'h169;

    typedef logic [BYTE_W-1:0] mds_byte_t;

    // One matrix row, indexed [col]; byte 0 is the coefficient applied to y0.
    typedef logic [LANES-1:0][BYTE_W-1:0] mds_row_t;

    // MDS_M[row][col]
    localparam mds_row_t [LANES-1:0] MDS_M = {
        32'h5BEF01EF,   // row3 = EF 01 EF 5B
        32'hEF015BEF,   // row2 = EF 5B 01 EF
        32'h01EFEF5B,   // row1 = 5B EF EF 01
        32'h5B5BEF01    // row0 = 01 EF 5B 5B
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Read byte lane idx of a 32-bit word.
    function automatic mds_byte_t byte_lane(input logic [WORD_W-1:0] w,
                                            input logic [1:0]        idx);
        return w[BYTE_W*idx +: BYTE_W];
    endfunction

    // Return w with byte lane idx replaced by b.
    function automatic logic [WORD_W-1:0] put_lane(input logic [WORD_W-1:0] w,
                                                   input logic [1:0]        idx,
                                                   input mds_byte_t         b);
        logic [WORD_W-1:0] r;
        r = w;
        r[BYTE_W*idx +: BYTE_W] = b;
        return r;
    endfunction

endpackage

// File: rtl/mds_seq_if.sv
// Word-level valid/ready bus of the MDS sequencer.
// master: the surrounding g/h datapath (drives input word, consumes result).
// slave : mds_seq.
//   in_valid/in_ready/in_word    : input word y, byte lane i = y_i
//   out_valid/out_ready/out_word : result word z, byte lane i = z_i
interface mds_seq_if;
    import mds_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_word;

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_word
    );

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, out_word
    );

endinterface

// File: rtl/mds_gf_mul.sv
// Combinational GF(2^8) multiply, reduced modulo POLY.
// Ports: a, b (8-bit operands), prod_c (8-bit product).
module mds_gf_mul
    import mds_pkg::*;
#(
    parameter logic [8:0] POLY = MDS_POLY
) (
    input  mds_byte_t a,
    input  mds_byte_t b,
    output mds_byte_t prod_c
);

    // Shift-and-add: sh walks a*x^i, reduced each step.
    always_comb begin
        mds_byte_t sh;
        prod_c = '0;
        sh     = a;
        for (int i = 0; i < int'(BYTE_W); i++) begin
            if (b[i]) begin
                prod_c = prod_c ^ sh;
            end
            sh = {sh[BYTE_W-2:0], 1'b0} ^ (sh[BYTE_W-1] ? POLY[BYTE_W-1:0] : 8'h00);
        end
    end

endmodule

// File: rtl/mds_seq.sv
// Serial Twofish MDS matrix multiply: z = M * y over GF(2^8).
// One multiplier and one accumulator are time-shared over the 16 terms
// (IDLE -> MAC x16 -> DONE). With MDS_SEQ_ROWPAR_EN defined, four
// multipliers compute a full row per cycle (MAC x4).
// Ports:
//   clk, reset (async, active-low)
//   clr      : synchronous abort back to IDLE, drops the in-flight word
//   bus      : mds_seq_if slave (input word / result handshakes)
//   busy     : high whenever not in IDLE
//   op_count : results delivered, wraps
module mds_seq
    import mds_pkg::*;
#(
    parameter logic [8:0]  POLY       = MDS_POLY,
    parameter int unsigned BUSY_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    mds_seq_if.slave              bus,
    output logic                  busy,
    output logic [BUSY_CNT_W-1:0] op_count
);

    state_t                state_q, state_d;
    logic [1:0]            row_q, row_d;
    logic [1:0]            col_q, col_d;
    mds_byte_t             acc_q, acc_d;
    logic [WORD_W-1:0]     y_q, y_d;
    logic [WORD_W-1:0]     res_q, res_d;
    logic [WORD_W-1:0]     out_word_q, out_word_d;
    logic                  out_valid_q, out_valid_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;
    logic [BUSY_CNT_W-1:0] op_count_q, op_count_d;

    mds_byte_t             term_c;
    mds_byte_t             acc_new_c;

`ifdef MDS_SEQ_ROWPAR_EN
    // Whole row per cycle: col never advances, every MAC cycle closes a row.
    localparam logic [1:0] COL_LAST = 2'd0;

    mds_byte_t prod_c [LANES];

    for (genvar k = 0; k < int'(LANES); k++) begin : g_mul
        mds_gf_mul #(.POLY(POLY)) u_mul (
            .a      (MDS_M[row_q][k]),
            .b      (byte_lane(y_q, 2'(k))),
            .prod_c (prod_c[k])
        );
    end

    assign term_c = prod_c[0] ^ prod_c[1] ^ prod_c[2] ^ prod_c[3];
`else
    localparam logic [1:0] COL_LAST = 2'd3;

    mds_gf_mul #(.POLY(POLY)) u_mul (
        .a      (MDS_M[row_q][col_q]),
        .b      (byte_lane(y_q, col_q)),
        .prod_c (term_c)
    );
`endif

    assign acc_new_c = acc_q ^ term_c;

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        acc_d       = acc_q;
        y_d         = y_q;
        res_d       = res_q;
        out_word_d  = out_word_q;
        out_valid_d = out_valid_q;
        op_count_d  = op_count_q;

        if (clr) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            acc_d       = '0;
            row_d       = '0;
            col_d       = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        y_d     = bus.in_word;
                        row_d   = '0;
                        col_d   = '0;
                        acc_d   = '0;
                        state_d = MAC;
                    end
                end
                MAC: begin
                    if (col_q == COL_LAST) begin
                        res_d = put_lane(res_q, row_q, acc_new_c);
                        acc_d = '0;
                        col_d = '0;
                        row_d = row_q + 2'd1;
                        if (row_q == 2'd3) begin
                            state_d = DONE;
                        end
                    end else begin
                        acc_d = acc_new_c;
                        col_d = col_q + 2'd1;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; later ones wait for the consumer.
                    if (!out_valid_q) begin
                        out_valid_d = 1'b1;
                        out_word_d  = res_q;
                    end else if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        op_count_d  = op_count_q + BUSY_CNT_W'(1);
                        state_d     = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            acc_q       <= '0;
            y_q         <= '0;
            res_q       <= '0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            acc_q       <= acc_d;
            y_q         <= y_d;
            res_q       <= res_d;
            out_word_q  <= out_word_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            op_count_q  <= op_count_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
    assign busy          = busy_q;
    assign op_count      = op_count_q;

endmodule

// File: tb/tb_mds_seq.sv
// Directed and random-regression bench for mds_seq.
module tb_mds_seq;
    import mds_pkg::*;

    localparam int unsigned CNT_W = 16;
`ifdef MDS_SEQ_ROWPAR_EN
    localparam int LAT      = 5;
    localparam int CLR_WAIT = 2;
`else
    localparam int LAT      = 17;
    localparam int CLR_WAIT = 6;
`endif

    localparam logic [7:0] TB_M [4][4] = '{
        '{8'h01, 8'hEF, 8'h5B, 8'h5B},
        '{8'h5B, 8'hEF, 8'hEF, 8'h01},
        '{8'hEF, 8'h5B, 8'h01, 8'hEF},
        '{8'hEF, 8'h01, 8'hEF, 8'h5B}
    };

    logic             clk = 1'b0;
    logic             reset;
    logic             clr;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    mds_seq_if bus ();

    mds_seq #(.POLY(9'h169), .BUSY_CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .bus      (bus),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Horner-form GF(2^8) multiply modulo 0x169.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            r = r[7] ? ({r[6:0], 1'b0} ^ 8'h69) : {r[6:0], 1'b0};
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    function automatic logic [31:0] mds_model(input logic [31:0] y);
        logic [31:0] z;
        logic [7:0]  acc;
        z = 32'h0;
        for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int c = 0; c < 4; c++) acc = acc ^ gm(TB_M[r][c], y[8*c +: 8]);
            z[8*r +: 8] = acc;
        end
        return z;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, want);
        end
    endtask

    // Present w, wait for accept, then for out_valid; check latency and result.
    task automatic run_word(input string tag, input logic [31:0] w, input logic [31:0] want);
        int n;
        n = 0;
        bus.in_word  = w;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(LAT));
        check({tag, "_word"}, bus.out_word, want);
        if (bus.out_ready) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        clr           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_word   = 32'h0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_word",  bus.out_word,       32'h0);
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_op_count",  32'(op_count),      32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(bus.in_ready), 32'd1);

        // Directed vectors
        bus.out_ready = 1'b1;
        run_word("y0_one", 32'h00000001, 32'hEFEF5B01);
        check("post_out_valid", 32'(bus.out_valid), 32'd0);
        check("post_op_count",  32'(op_count),      32'd1);
        check("post_busy",      32'(busy),          32'd0);
        run_word("y1_one",   32'h00000100, 32'h015BEFEF);
        run_word("y01_lin",  32'h00000101, 32'hEEB4B4EE);
        run_word("y0_two",   32'h00000002, 32'hB7B7B602);
        run_word("y3_one",   32'h01000000, 32'h5BEF015B);
        check("op_count_5", 32'(op_count), 32'd5);

        // Backpressure: hold result for 10 cycles while a second word knocks
        bus.out_ready = 1'b0;
        run_word("bp", 32'h00010000, 32'hEF01EF5B);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_word  = 32'h00000001;
            @(negedge clk);
            check("bp_word",      bus.out_word,       32'hEF01EF5B);
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_op_count",  32'(op_count),      32'd5);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_out_valid", 32'(bus.out_valid), 32'd0);
        check("bp_rel_op_count",  32'(op_count),      32'd6);
        check("bp_rel_busy",      32'(busy),          32'd0);

        // clr mid-MAC together with a new in_valid
        bus.in_word  = 32'h00000001;
        bus.in_valid = 1'b1;
        while (!bus.in_ready) @(negedge clk);
        @(negedge clk);
        repeat (CLR_WAIT) @(negedge clk);
        check("clr_pre_busy", 32'(busy), 32'd1);
        clr          = 1'b1;
        bus.in_word  = 32'h00000100;
        @(negedge clk);
        clr = 1'b0;
        check("clr_busy",      32'(busy),          32'd0);
        check("clr_in_ready",  32'(bus.in_ready),  32'd1);
        check("clr_out_valid", 32'(bus.out_valid), 32'd0);
        check("clr_op_count",  32'(op_count),      32'd6);
        run_word("clr_next", 32'h00000100, 32'h015BEFEF);
        check("clr_next_op_count", 32'(op_count), 32'd7);

        // Async reset mid-MAC
        bus.in_word  = 32'h12345678;
        bus.in_valid = 1'b1;
        while (!bus.in_ready) @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_busy",      32'(busy),          32'd0);
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_out_word",  bus.out_word,       32'h0);
        check("arst_op_count",  32'(op_count),      32'd0);
        check("arst_in_ready",  32'(bus.in_ready),  32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Random regression against the software model
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] w;
            w = $urandom;
            run_word("rnd", w, mds_model(w));
        end
        check("rnd_op_count", 32'(op_count), 32'd1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
